// File: rtl/sdram_port_arbiter.sv
// Shares the single SDRAM request port between the refresh timer, the HPS ioctl
// download buffer and the Next186Lite CPU bus (fixed priority in that order).
module sdram_port_arbiter #(
  parameter int unsigned       ADDR_W      = 21,
  parameter int unsigned       RFSH_CYCLES = 447,
  parameter logic [ADDR_W-1:0] DL_BASE     = 21'h000000
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic              dl_err,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              cpu_ack,
  output logic              mem_req,
  output logic              mem_rfsh,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout,
  input  logic              mem_ack
);

  localparam int unsigned CNT_W = (RFSH_CYCLES > 1) ? $clog2(RFSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RFSH_LAST = CNT_W'(RFSH_CYCLES - 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_RFSH,
    OWN_DL,
    OWN_CPU
  } owner_e;

  state_e state_q, state_d;
  owner_e owner_q, owner_d;

  logic [CNT_W-1:0]  rfshCnt_q, rfshCnt_d;
  logic [1:0]        rfshPend_q, rfshPend_d;

  logic              dlFull_q, dlFull_d;
  logic [ADDR_W-1:0] dlAddr_q, dlAddr_d;
  logic [7:0]        dlData_q, dlData_d;
  logic              dlErr_q, dlErr_d;
  logic              dlPrev_q;

  logic              memReq_q, memReq_d;
  logic              memRfsh_q, memRfsh_d;
  logic              memWe_q, memWe_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [7:0]        memDin_q, memDin_d;
  logic              cpuAck_q, cpuAck_d;
  logic [7:0]        cpuDout_q, cpuDout_d;

  logic rfshWrap;
  logic rfshGrant;
  logic dlGrant;
  logic cpuGrant;
  logic cpuElig;
  logic dlInRange;
  logic dlAccept;
  logic dlDrop;
  logic dlRise;
  logic dlDone;

  // Grant decisions are only meaningful in IDLE; refresh always wins.
  assign rfshWrap  = (rfshCnt_q == RFSH_LAST);
  assign cpuElig   = cpu_req && !cpuAck_q && !ioctl_download && !dlFull_q;
  assign rfshGrant = (state_q == IDLE) && (rfshPend_q != 2'd0);
  assign dlGrant   = (state_q == IDLE) && (rfshPend_q == 2'd0) && dlFull_q;
  assign cpuGrant  = (state_q == IDLE) && (rfshPend_q == 2'd0) && !dlFull_q && cpuElig;

  assign dlInRange = (ioctl_addr[24:21] == 4'd0);
  assign dlAccept  = ioctl_wr && dlInRange && !dlFull_q;
  assign dlDrop    = ioctl_wr && !dlAccept;
  assign dlRise    = ioctl_download && !dlPrev_q;
  assign dlDone    = (state_q == BUSY) && mem_ack && (owner_q == OWN_DL);

  always_comb begin
    rfshCnt_d  = rfshWrap ? '0 : rfshCnt_q + CNT_W'(1);
    rfshPend_d = rfshPend_q;
    if (rfshWrap && !rfshGrant) begin
      if (rfshPend_q != 2'd3) begin
        rfshPend_d = rfshPend_q + 2'd1;
      end
    end else if (rfshGrant && !rfshWrap) begin
      rfshPend_d = rfshPend_q - 2'd1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rfshCnt_q  <= '0;
      rfshPend_q <= 2'd0;
    end else begin
      rfshCnt_q  <= rfshCnt_d;
      rfshPend_q <= rfshPend_d;
    end
  end

  // A dropped write sets dl_err even in the cycle a new download starts.
  always_comb begin
    dlFull_d = dlFull_q;
    dlAddr_d = dlAddr_q;
    dlData_d = dlData_q;
    dlErr_d  = dlErr_q;
    if (dlDone) begin
      dlFull_d = 1'b0;
    end
    if (dlAccept) begin
      dlFull_d = 1'b1;
      dlAddr_d = DL_BASE + ADDR_W'(ioctl_addr[20:0]);
      dlData_d = ioctl_dout;
    end
    if (dlRise) begin
      dlErr_d = 1'b0;
    end
    if (dlDrop) begin
      dlErr_d = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dlFull_q <= 1'b0;
      dlAddr_q <= '0;
      dlData_q <= 8'd0;
      dlErr_q  <= 1'b0;
      dlPrev_q <= 1'b0;
    end else begin
      dlFull_q <= dlFull_d;
      dlAddr_q <= dlAddr_d;
      dlData_q <= dlData_d;
      dlErr_q  <= dlErr_d;
      dlPrev_q <= ioctl_download;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (rfshGrant || dlGrant || cpuGrant) begin
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Memory-side outputs are registered from the winner and frozen while BUSY.
  always_comb begin
    memReq_d  = memReq_q;
    memRfsh_d = memRfsh_q;
    memWe_d   = memWe_q;
    memAddr_d = memAddr_q;
    memDin_d  = memDin_q;
    owner_d   = owner_q;
    cpuAck_d  = 1'b0;
    cpuDout_d = cpuDout_q;
    case (state_q)
      IDLE: begin
        if (rfshGrant) begin
          memReq_d  = 1'b1;
          memRfsh_d = 1'b1;
          memWe_d   = 1'b0;
          memAddr_d = '0;
          memDin_d  = 8'd0;
          owner_d   = OWN_RFSH;
        end else if (dlGrant) begin
          memReq_d  = 1'b1;
          memRfsh_d = 1'b0;
          memWe_d   = 1'b1;
          memAddr_d = dlAddr_q;
          memDin_d  = dlData_q;
          owner_d   = OWN_DL;
        end else if (cpuGrant) begin
          memReq_d  = 1'b1;
          memRfsh_d = 1'b0;
          memWe_d   = cpu_we;
          memAddr_d = cpu_addr;
          memDin_d  = cpu_din;
          owner_d   = OWN_CPU;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          memReq_d  = 1'b0;
          memRfsh_d = 1'b0;
          owner_d   = OWN_NONE;
          if (owner_q == OWN_CPU) begin
            cpuAck_d = 1'b1;
            if (!memWe_q) begin
              cpuDout_d = mem_dout;
            end
          end
        end
      end
      default: begin
        memReq_d  = 1'b0;
        memRfsh_d = 1'b0;
        owner_d   = OWN_NONE;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      memReq_q  <= 1'b0;
      memRfsh_q <= 1'b0;
      memWe_q   <= 1'b0;
      memAddr_q <= '0;
      memDin_q  <= 8'd0;
      owner_q   <= OWN_NONE;
      cpuAck_q  <= 1'b0;
      cpuDout_q <= 8'd0;
    end else begin
      memReq_q  <= memReq_d;
      memRfsh_q <= memRfsh_d;
      memWe_q   <= memWe_d;
      memAddr_q <= memAddr_d;
      memDin_q  <= memDin_d;
      owner_q   <= owner_d;
      cpuAck_q  <= cpuAck_d;
      cpuDout_q <= cpuDout_d;
    end
  end

  assign ioctl_wait = dlFull_q;
  assign dl_err     = dlErr_q;
  assign cpu_dout   = cpuDout_q;
  assign cpu_ack    = cpuAck_q;
  assign mem_req    = memReq_q;
  assign mem_rfsh   = memRfsh_q;
  assign mem_we     = memWe_q;
  assign mem_addr   = memAddr_q;
  assign mem_din    = memDin_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with a small SDRAM controller responder
// that logs every mem_req it accepts and answers after a programmable latency.
module tb_sdram_port_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;
  logic        dl_err;
  logic        cpu_req;
  logic        cpu_we;
  logic [20:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        cpu_ack;
  logic        mem_req;
  logic        mem_rfsh;
  logic        mem_we;
  logic [20:0] mem_addr;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic        mem_ack;

  int vectors = 0;
  int miscompares = 0;

  int          latency = 2;
  logic [7:0]  respData = 8'h00;
  int          cycleNo = 0;
  int          logN = 0;
  int          lastAckCycle = 0;
  logic        logRfsh [64];
  logic        logWe [64];
  logic [20:0] logAddr [64];
  logic [7:0]  logDin [64];
  int          logCycle [64];

  int base = 0;
  int logBase = 0;

  sdram_port_arbiter #(
    .ADDR_W(21),
    .RFSH_CYCLES(447),
    .DL_BASE(21'h1F0000)
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout),
    .ioctl_wait(ioctl_wait),
    .dl_err(dl_err),
    .cpu_req(cpu_req),
    .cpu_we(cpu_we),
    .cpu_addr(cpu_addr),
    .cpu_din(cpu_din),
    .cpu_dout(cpu_dout),
    .cpu_ack(cpu_ack),
    .mem_req(mem_req),
    .mem_rfsh(mem_rfsh),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_din(mem_din),
    .mem_dout(mem_dout),
    .mem_ack(mem_ack)
  );

  always #5 clk_sys = ~clk_sys;

  // Controller model: runs 1 time unit after each rising edge, before the stimulus.
  initial begin
    bit tracking;
    int countdown;
    tracking  = 1'b0;
    countdown = 0;
    mem_ack   = 1'b0;
    mem_dout  = 8'h00;
    forever begin
      @(posedge clk_sys);
      #1;
      cycleNo++;
      if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (tracking) begin
        countdown--;
        if (countdown <= 0) begin
          mem_ack      = 1'b1;
          mem_dout     = respData;
          tracking     = 1'b0;
          lastAckCycle = cycleNo;
        end
      end else if (mem_req) begin
        if (logN < 64) begin
          logRfsh[logN]  = mem_rfsh;
          logWe[logN]    = mem_we;
          logAddr[logN]  = mem_addr;
          logDin[logN]   = mem_din;
          logCycle[logN] = cycleNo;
          logN++;
        end
        countdown = latency;
        tracking  = 1'b1;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int relCycle();
    return cycleNo - base;
  endfunction

  task automatic tick();
    @(posedge clk_sys);
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic we, input logic [20:0] addr,
                               input logic [7:0] din);
    cpu_req  = req;
    cpu_we   = we;
    cpu_addr = addr;
    cpu_din  = din;
  endtask

  task automatic clearInputs();
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = 25'd0;
    ioctl_dout     = 8'd0;
    applyStimulus(1'b0, 1'b0, 21'd0, 8'd0);
  endtask

  // Leaves the bench in cycle 0: reset released during this cycle.
  task automatic doReset();
    tick();
    reset_n = 1'b0;
    clearInputs();
    tick();
    tick();
    tick();
    reset_n = 1'b1;
    base    = cycleNo;
    logBase = logN;
  endtask

  task automatic waitCpuAck(input int maxCycles, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < maxCycles && !seen; i++) begin
      tick();
      if (cpu_ack) seen = 1'b1;
    end
  endtask

  task automatic waitWaitLow(input int maxCycles, output bit fell);
    fell = 1'b0;
    for (int i = 0; i < maxCycles && !fell; i++) begin
      tick();
      if (!ioctl_wait) fell = 1'b1;
    end
  endtask

  initial begin
    bit seen;
    bit fell;
    int ackCycle;
    int li;
    int sawReq;
    int sawAck;
    int sawWait;

    reset_n = 1'b0;
    clearInputs();
    tick();
    tick();
    tick();
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_mem_rfsh", mem_rfsh, 0);
    checkOutput("rst_mem_we", mem_we, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_cpu_ack", cpu_ack, 0);
    checkOutput("rst_cpu_dout", cpu_dout, 0);
    checkOutput("rst_ioctl_wait", ioctl_wait, 0);
    checkOutput("rst_dl_err", dl_err, 0);

    // Idle refresh: wraps at edge 447, grant seen as mem_req in cycle 448, then 895.
    doReset();
    latency = 2;
    repeat (900) tick();
    checkOutput("rfsh_count", logN - logBase, 2);
    checkOutput("rfsh0_flag", logRfsh[logBase], 1);
    checkOutput("rfsh0_we", logWe[logBase], 0);
    checkOutput("rfsh0_addr", logAddr[logBase], 0);
    checkOutput("rfsh0_window", (logCycle[logBase] - base >= 447) && (logCycle[logBase] - base <= 449), 1);
    checkOutput("rfsh1_flag", logRfsh[logBase + 1], 1);
    checkOutput("rfsh1_cycle", logCycle[logBase + 1] - base, 895);

    // CPU read with a 3-cycle controller: mem_req cycle 2, mem_ack 5, cpu_ack 6.
    doReset();
    latency  = 3;
    respData = 8'hA5;
    tick();
    applyStimulus(1'b1, 1'b0, 21'h0F0010, 8'h00);
    waitCpuAck(40, seen);
    checkOutput("cpu_rd_ack_seen", seen, 1);
    ackCycle = relCycle();
    checkOutput("cpu_rd_ack_cycle", ackCycle, 6);
    checkOutput("cpu_rd_ack_after_mem_ack", ackCycle, lastAckCycle - base + 1);
    checkOutput("cpu_rd_dout", cpu_dout, 8'hA5);
    tick();
    checkOutput("cpu_rd_ack_single", cpu_ack, 0);
    applyStimulus(1'b0, 1'b0, 21'h0F0010, 8'h00);
    repeat (10) tick();
    checkOutput("cpu_rd_one_access", logN - logBase, 1);
    checkOutput("cpu_rd_addr", logAddr[logBase], 21'h0F0010);
    checkOutput("cpu_rd_we", logWe[logBase], 0);
    checkOutput("cpu_rd_rfsh", logRfsh[logBase], 0);
    checkOutput("cpu_rd_req_cycle", logCycle[logBase] - base, 2);

    // CPU write: read data register must keep the earlier value.
    latency  = 1;
    respData = 8'h33;
    applyStimulus(1'b1, 1'b1, 21'h000123, 8'h5A);
    waitCpuAck(40, seen);
    checkOutput("cpu_wr_ack_seen", seen, 1);
    checkOutput("cpu_wr_dout_kept", cpu_dout, 8'hA5);
    tick();
    applyStimulus(1'b0, 1'b0, 21'd0, 8'd0);
    repeat (4) tick();
    checkOutput("cpu_wr_one_access", logN - logBase, 2);
    checkOutput("cpu_wr_we", logWe[logBase + 1], 1);
    checkOutput("cpu_wr_addr", logAddr[logBase + 1], 21'h000123);
    checkOutput("cpu_wr_din", logDin[logBase + 1], 8'h5A);

    // Four-byte download to DL_BASE..DL_BASE+3.
    doReset();
    latency = 2;
    tick();
    ioctl_download = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(i);
      ioctl_dout = 8'(8'h10 + i);
      tick();
      ioctl_wr = 1'b0;
      checkOutput("dl_wait_high", ioctl_wait, 1);
      waitWaitLow(30, fell);
      checkOutput("dl_wait_fell", fell, 1);
      checkOutput("dl_wait_ack_plus1", relCycle(), lastAckCycle - base + 1);
    end
    ioctl_download = 1'b0;
    tick();
    checkOutput("dl_err_clean", dl_err, 0);
    checkOutput("dl_count", logN - logBase, 4);
    for (int i = 0; i < 4; i++) begin
      li = logBase + i;
      checkOutput("dl_addr", logAddr[li], 21'h1F0000 + 21'(i));
      checkOutput("dl_din", logDin[li], 8'(8'h10 + i));
      checkOutput("dl_we", logWe[li], 1);
      checkOutput("dl_rfsh", logRfsh[li], 0);
    end

    // Out-of-range write, clear on new download, then an overrun.
    doReset();
    tick();
    ioctl_download = 1'b1;
    tick();
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'h0200000;
    ioctl_dout = 8'hEE;
    tick();
    ioctl_wr = 1'b0;
    checkOutput("oor_err_set", dl_err, 1);
    checkOutput("oor_no_wait", ioctl_wait, 0);
    repeat (6) tick();
    checkOutput("oor_no_mem_req", logN - logBase, 0);
    ioctl_download = 1'b0;
    tick();
    ioctl_download = 1'b1;
    tick();
    checkOutput("oor_err_cleared", dl_err, 0);
    latency    = 5;
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'h10;
    ioctl_dout = 8'h42;
    tick();
    ioctl_addr = 25'h11;
    ioctl_dout = 8'h43;
    tick();
    ioctl_wr = 1'b0;
    checkOutput("ovr_err_set", dl_err, 1);
    waitWaitLow(30, fell);
    checkOutput("ovr_wait_fell", fell, 1);
    checkOutput("ovr_one_write", logN - logBase, 1);
    checkOutput("ovr_addr", logAddr[logBase], 21'h1F0010);
    checkOutput("ovr_din", logDin[logBase], 8'h42);

    // Refresh, download and CPU all pending in IDLE cycle 447.
    doReset();
    latency  = 2;
    respData = 8'h6C;
    tick();
    ioctl_download = 1'b1;
    while (relCycle() < 440) tick();
    applyStimulus(1'b1, 1'b0, 21'h000200, 8'h00);
    while (relCycle() < 446) tick();
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'h40;
    ioctl_dout = 8'h77;
    tick();
    ioctl_wr = 1'b0;
    checkOutput("prio_buf_full", ioctl_wait, 1);
    tick();
    tick();
    ioctl_download = 1'b0;
    waitCpuAck(60, seen);
    checkOutput("prio_cpu_ack_seen", seen, 1);
    checkOutput("prio_cpu_ack_cycle", relCycle(), 459);
    checkOutput("prio_cpu_dout", cpu_dout, 8'h6C);
    tick();
    applyStimulus(1'b0, 1'b0, 21'd0, 8'd0);
    repeat (4) tick();
    checkOutput("prio_count", logN - logBase, 3);
    checkOutput("prio0_rfsh", logRfsh[logBase], 1);
    checkOutput("prio0_cycle", logCycle[logBase] - base, 448);
    checkOutput("prio1_we", logWe[logBase + 1], 1);
    checkOutput("prio1_addr", logAddr[logBase + 1], 21'h1F0040);
    checkOutput("prio1_din", logDin[logBase + 1], 8'h77);
    checkOutput("prio1_cycle", logCycle[logBase + 1] - base, 452);
    checkOutput("prio2_rfsh", logRfsh[logBase + 2], 0);
    checkOutput("prio2_addr", logAddr[logBase + 2], 21'h000200);
    checkOutput("prio2_cycle", logCycle[logBase + 2] - base, 456);
    checkOutput("prio_dl_err", dl_err, 0);

    // Reset asserted mid-access; the late controller ack lands in IDLE.
    doReset();
    latency = 10;
    tick();
    ioctl_download = 1'b1;
    tick();
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'h5;
    ioctl_dout = 8'h99;
    tick();
    ioctl_wr = 1'b0;
    tick();
    checkOutput("arst_busy_req", mem_req, 1);
    checkOutput("arst_busy_wait", ioctl_wait, 1);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("arst_mem_req", mem_req, 0);
    checkOutput("arst_ioctl_wait", ioctl_wait, 0);
    checkOutput("arst_cpu_ack", cpu_ack, 0);
    ioctl_download = 1'b0;
    tick();
    reset_n = 1'b1;
    sawReq  = 0;
    sawAck  = 0;
    sawWait = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (mem_req) sawReq++;
      if (cpu_ack) sawAck++;
      if (ioctl_wait) sawWait++;
    end
    checkOutput("arst_no_req_after", sawReq, 0);
    checkOutput("arst_no_ack_after", sawAck, 0);
    checkOutput("arst_no_wait_after", sawWait, 0);
    checkOutput("arst_one_access", logN - logBase, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single external memory port (the SDRAM controller's byte-wide request/acknowledge interface) between three requesters:
  - the periodic refresh generator (internal to this block);
  - the HPS ioctl download path (BIOS/ROM/disk image loading);
  - the Next186Lite CPU/SRAM-style bus.
- Sits between hps_io / the Next186Lite core and the SDRAM controller in emu.
- Replaces the direct SRAM_A/SRAM_D/SRAM_WE_n wiring to SDRAM pins.

Parameters:
- ADDR_W, 21, memory byte-address width (2 MB).
- RFSH_CYCLES, 447, clk_sys cycles between refresh requests (15.6 us at 28.636 MHz).
- DL_BASE, 21'h000000, memory address at which ioctl_addr 0 is written.

Ports:
- clk_sys  in  1  system clock (28.636 MHz).
- reset_n  in  1  asynchronous active-low reset.
- ioctl_download  in  1  download in progress (from hps_io).
- ioctl_wr  in  1  single-cycle write strobe.
- ioctl_addr  in  25  download byte address.
- ioctl_dout  in  8  download data byte.
- ioctl_wait  out  1  backpressure to hps_io.
- dl_err  out  1  sticky: download write dropped (out of range or overrun).
- cpu_req  in  1  CPU access request; level, held until cpu_ack.
- cpu_we  in  1  1 = write.
- cpu_addr  in  ADDR_W  CPU byte address.
- cpu_din  in  8  CPU write data.
- cpu_dout  out  8  CPU read data.
- cpu_ack  out  1  one-cycle completion pulse.
- mem_req  out  1  request to the SDRAM controller; held until mem_ack.
- mem_rfsh  out  1  qualifies mem_req as an auto-refresh command.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  byte address.
- mem_din  out  8  write data.
- mem_dout  in  8  read data, valid in the mem_ack cycle.
- mem_ack  in  1  one-cycle completion from the controller.

Behaviour:
- Reset (reset_n=0, asynchronous): all outputs 0; state IDLE; refresh counter 0; rfsh_pend 0; download buffer empty; dl_err 0. Any access in flight is abandoned; the memory controller is reset from the same source.
- Refresh timer:
  - Counts 0..RFSH_CYCLES-1 and wraps.
  - Each wrap increments rfsh_pend, a 2-bit count that saturates at 3.
  - A granted refresh decrements it.
  - Wrap and grant in the same cycle: count unchanged.
- Download buffer (one entry):
  - On ioctl_wr with buffer empty: latch addr = DL_BASE + ioctl_addr[20:0] (mod 2^21) and the data; set full.
  - ioctl_wait is registered: 1 from the cycle after ioctl_wr until the cycle after the buffered write's mem_ack.
  - ioctl_wr with ioctl_addr[24:21] != 0: not buffered, no memory access, dl_err set.
  - ioctl_wr while the buffer is full: dropped, dl_err set.
  - dl_err clears on the rising edge of ioctl_download.
  - ioctl_download falling while the buffer is full: the write still completes.
- CPU eligibility:
  - Eligible when cpu_req=1, cpu_ack=0, and ioctl_download=0 with the buffer empty.
  - The CPU is starved for the whole download; by design it is held in reset during downloads.
- FSM states IDLE, BUSY.
  - IDLE: priority refresh (rfsh_pend>0), then download buffer, then CPU.
    - On grant, next cycle: BUSY, mem_req=1, with mem_rfsh/mem_we/mem_addr/mem_din registered from the winner.
    - Refresh grant: mem_rfsh=1, mem_we=0, mem_addr=0.
    - Download grant: mem_we=1.
  - BUSY: all mem_* outputs held stable until mem_ack.
    - On mem_ack: mem_req=0 and mem_rfsh=0 next cycle; state IDLE.
    - For a CPU grant: cpu_dout captures mem_dout in the mem_ack cycle (reads only; unchanged on writes), and cpu_ack=1 for the single next cycle.
    - For a download grant: buffer empty next cycle.
- Latency: CPU request seen in IDLE at cycle N → mem_req at N+1 → cpu_ack at mem_ack+1.
- Back-to-back: IDLE may grant again in the cycle after mem_ack (one idle cycle minimum between mem_req pulses).
- mem_ack while in IDLE: ignored.

Test Plan:
- Reset release, idle for 900 cycles → exactly 2 refresh grants (mem_req with mem_rfsh=1), the first at cycle 448 ± 1; no other mem_req.
- CPU read of 21'h0F0010, controller returns 8'hA5 after 3 cycles → mem_addr=21'h0F0010, mem_we=0; cpu_dout=8'hA5 with cpu_ack the cycle after mem_ack, exactly one pulse; cpu_req held one extra cycle → no second access.
- Download of 4 bytes (ioctl_addr 0..3, DL_BASE=21'h1F0000) → writes to 21'h1F0000..1F0003 in order; ioctl_wait high per byte until ack+1; dl_err=0.
- ioctl_addr=25'h0200000 → no mem_req, dl_err=1; new ioctl_download rising edge → dl_err=0.
- Refresh wrap, pending download write and cpu_req all in the same IDLE cycle → order refresh, download, then CPU (after ioctl_download=0).
- reset_n pulled low during BUSY → mem_req, cpu_ack and ioctl_wait drop asynchronously; no ack is issued after release.
